// File: rtl/retire_halt_monitor_if.sv
// Retire-port bundle between a core's writeback (W) stage and retire_halt_monitor.
//   retire_valid : one instruction retires this cycle
//   retire_pc    : PC of the retiring instruction (pcW)
//   retire_instr : retiring instruction word
// Modports: master = core side (drives), slave = monitor side (observes).
interface retire_halt_monitor_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [31:0]     retire_instr;

    modport master (output retire_valid, output retire_pc, output retire_instr);
    modport slave  (input  retire_valid, input  retire_pc, input  retire_instr);
endinterface

// File: rtl/retire_halt_monitor.sv
// retire_halt_monitor: run monitor on the core retire port.
// Counts RUN cycles and retired instructions and ends the run on a halt PC, a self-loop
// (same PC retired LOOP_THRESH times in a row) or a cycle timeout. done/halt_cause are sticky
// until reset.
// Ports:
//   clk          : core clock
//   rstn         : synchronous reset, active HIGH (1 = reset)
//   ret          : retire bundle (slave modport)
//   trace_rd_idx : trace read index, 0 = most recent
//   done         : run finished (sticky)
//   halt_cause   : 00 none, 01 halt PC, 10 self-loop, 11 timeout
//   cycle_cnt    : RUN-state cycles (saturating)
//   instret_cnt  : retired instructions (saturating)
//   last_pc      : PC of the most recent counted retirement
//   last_instr   : instruction of the most recent counted retirement
//   trace_rd_pc  : trace ring entry selected by trace_rd_idx (combinational)
// Optional feature: define TRACE_BUF_EN to build the TRACE_DEPTH-entry PC trace ring;
// otherwise trace_rd_pc is tied to 0.
module retire_halt_monitor #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_W       = 32,
    parameter logic [XLEN-1:0] HALT_PC     = 'h000000ff,
    parameter int unsigned     LOOP_THRESH = 4,
    parameter int unsigned     TIMEOUT     = 100000,
    parameter int unsigned     TRACE_DEPTH = 8,
    localparam int unsigned    IDX_W       = $clog2(TRACE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    retire_halt_monitor_if.slave  ret,
    input  logic [IDX_W-1:0]      trace_rd_idx,
    output logic                  done,
    output logic [1:0]            halt_cause,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret_cnt,
    output logic [XLEN-1:0]       last_pc,
    output logic [31:0]           last_instr,
    output logic [XLEN-1:0]       trace_rd_pc
);
    localparam int unsigned LOOP_W = $clog2(LOOP_THRESH + 1);

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseHaltPc  = 2'b01;
    localparam logic [1:0] CauseLoop    = 2'b10;
    localparam logic [1:0] CauseTimeout = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;
    logic [31:0]       last_instr_q, last_instr_d;
    logic [LOOP_W-1:0] loop_q, loop_d;

    logic accept;
    logic halt_evt, loop_evt, timeout_evt, any_evt;

    // Retirements in DONE are ignored entirely.
    assign accept = ret.retire_valid && (state_q != StDone);

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        cycle_d      = cycle_q;
        instret_d    = instret_q;
        last_pc_d    = last_pc_q;
        last_instr_d = last_instr_q;
        loop_d       = loop_q;

        // instret_q != 0 keeps the reset value of last_pc from matching a first retire at PC 0.
        if (accept) begin
            if ((ret.retire_pc == last_pc_q) && (instret_q != '0)) begin
                loop_d = loop_q + LOOP_W'(1);
            end else begin
                loop_d = LOOP_W'(1);
            end
            last_pc_d    = ret.retire_pc;
            last_instr_d = ret.retire_instr;
            if (instret_q != '1) instret_d = instret_q + CNT_W'(1);
        end

        // Counts every RUN cycle plus the IDLE->RUN edge, so the first retirement gives 1.
        if ((state_q == StRun) || ((state_q == StIdle) && ret.retire_valid)) begin
            if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        end

        halt_evt    = accept && (ret.retire_pc == HALT_PC);
        loop_evt    = accept && (loop_d == LOOP_W'(LOOP_THRESH));
        // TIMEOUT==1 can only be met on the edge that leaves IDLE.
        timeout_evt = ((state_q == StRun) && (cycle_q == CNT_W'(TIMEOUT - 1))) ||
                      ((state_q == StIdle) && ret.retire_valid && (TIMEOUT == 1));
        any_evt     = halt_evt || loop_evt || timeout_evt;

        unique case (state_q)
            StIdle: begin
                if (ret.retire_valid) state_d = any_evt ? StDone : StRun;
            end
            StRun: begin
                if (any_evt) state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q != StDone) && any_evt) begin
            if (halt_evt)      cause_d = CauseHaltPc;
            else if (loop_evt) cause_d = CauseLoop;
            else               cause_d = CauseTimeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= StIdle;
            cause_q      <= CauseNone;
            cycle_q      <= '0;
            instret_q    <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
            loop_q       <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
            loop_q       <= loop_d;
        end
    end

    assign done        = (state_q == StDone);
    assign halt_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign last_pc     = last_pc_q;
    assign last_instr  = last_instr_q;

`ifdef TRACE_BUF_EN
    logic [XLEN-1:0]  ring_q [TRACE_DEPTH];
    logic [IDX_W-1:0] wptr_q;
    logic [IDX_W-1:0] rd_slot;

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < int'(TRACE_DEPTH); i++) ring_q[i] <= '0;
            wptr_q <= '0;
        end else if (accept) begin
            ring_q[wptr_q] <= ret.retire_pc;
            wptr_q         <= wptr_q + IDX_W'(1);
        end
    end

    // Power-of-two depth: IDX_W-bit arithmetic wraps modulo TRACE_DEPTH.
    assign rd_slot     = wptr_q - IDX_W'(1) - trace_rd_idx;
    assign trace_rd_pc = ring_q[rd_slot];
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_rd_idx;
    assign trace_rd_pc      = '0;
`endif
endmodule
